// File: rtl/approx_mult_pkg.sv
// Shared types and default sizing for the approximate sequential multiplier.
// Holds the FSM state encoding used by approx_seq_mult.
package approx_mult_pkg;

   localparam int WIDTH_DEF       = 8;
   localparam int APPROX_BITS_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

endpackage

// File: rtl/approx_accum_adder.sv
// Approximate accumulator adder: low columns OR-ed without carry,
// upper columns rippled exactly through full_adder cells.
module approx_accum_adder #(
   parameter int WIDTH       = 8,
   parameter int APPROX_BITS = 4
) (
   input  logic [2*WIDTH-1:0] x_i,
   input  logic [2*WIDTH-1:0] y_i,
   output logic [2*WIDTH-1:0] sum_o
);

   localparam int N = 2 * WIDTH;

   logic [N:APPROX_BITS] c;
   logic                 cout_unused;

   assign c[APPROX_BITS] = 1'b0;
   // Carry out of the top column is dropped: product wraps at 2*WIDTH bits.
   assign cout_unused = c[N];

   for (genvar j = 0; j < N; j++) begin : g_col
      if (j < APPROX_BITS) begin : g_or
         assign sum_o[j] = x_i[j] | y_i[j];
      end else begin : g_fa
         full_adder u_fa (
            .a_i(x_i[j]),
            .b_i(y_i[j]),
            .c_i(c[j]),
            .s_o(sum_o[j]),
            .c_o(c[j+1])
         );
      end
   end

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
// Basic building block for the exact columns of the accumulator.
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/approx_seq_mult.sv
// Shift-and-add unsigned multiplier, one multiplier bit per cycle,
// accumulating through an approximate low-column adder.
module approx_seq_mult
   import approx_mult_pkg::*;
#(
   parameter int WIDTH       = WIDTH_DEF,
   parameter int APPROX_BITS = APPROX_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic [2*WIDTH-1:0] addend;
   logic [2*WIDTH-1:0] sum;

   assign addend = {{WIDTH{1'b0}}, a_q} << cnt_q;

   approx_accum_adder #(
      .WIDTH(WIDTH),
      .APPROX_BITS(APPROX_BITS)
   ) u_add (
      .x_i(acc_q),
      .y_i(addend),
      .sum_o(sum)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (b_q[cnt_q]) acc_d = sum;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign product   = acc_q;

endmodule

// File: tb/tb_approx_seq_mult.sv
// Bench: seven multipliers (APPROX_BITS 0..6) share one stimulus stream;
// a scoreboard queue holds the expected products for each handshake.
module tb_approx_seq_mult;

   localparam int W  = 8;
   localparam int NK = 7;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid;
   logic                    out_ready;
   logic [W-1:0]            a;
   logic [W-1:0]            b;
   logic [NK-1:0]           ir;
   logic [NK-1:0]           ov;
   logic [NK-1:0][2*W-1:0]  pw;

   int checks = 0;
   int errors = 0;

   // Entry layout: [16*k +: 16] expected for APPROX_BITS=k, [127:112] exact a*b.
   logic [127:0] exp_q[$];

   always #5 clk = ~clk;

   for (genvar k = 0; k < NK; k++) begin : g_dut
      approx_seq_mult #(
         .WIDTH(W),
         .APPROX_BITS(k)
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .in_valid(in_valid),
         .in_ready(ir[k]),
         .a(a),
         .b(b),
         .out_valid(ov[k]),
         .out_ready(out_ready),
         .product(pw[k])
      );
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: sum of shifted partial products, low k columns merged by OR.
   function automatic longint model(input int x, input int y, input int k);
      longint acc, p, lo_mask, hi;
      acc     = 0;
      lo_mask = (longint'(1) << k) - 1;
      for (int i = 0; i < W; i++) begin
         if (((y >> i) & 1) == 1) begin
            p   = longint'(x) << i;
            hi  = ((acc >> k) + (p >> k)) << k;
            acc = (((acc | p) & lo_mask) | hi) & 64'hFFFF;
         end
      end
      return acc;
   endfunction

   always @(negedge clk) begin
      logic [127:0] e;
      if (!rst && ov[0] && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got handshake expected none");
         end else begin
            e = exp_q.pop_front();
            for (int k = 0; k < NK; k++) begin
               chk($sformatf("prod_k%0d", k), pw[k], e[16*k +: 16]);
               chk($sformatf("valid_k%0d", k), ov[k], 1);
               checks++;
               if (pw[k] > e[127:112]) begin
                  errors++;
                  $display("FAIL le_k%0d: got %0d expected <= %0d",
                           k, pw[k], e[127:112]);
               end
            end
         end
      end
   end

   task automatic send(input int x, input int y);
      logic [127:0] e;
      int n;
      n = 0;
      in_valid = 1'b1;
      a = W'(x);
      b = W'(y);
      while (!ir[0] && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("accept_ready", ir[0], 1);
      for (int k = 0; k < NK; k++) e[16*k +: 16] = 16'(model(x, y, k));
      e[127:112] = 16'(x * y);
      exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
   endtask

   task automatic wait_done();
      int lat;
      lat = 0;
      while (!ov[0] && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, W);
   endtask

   task automatic run_one(input int x, input int y, input int kidx,
                          input int expc, input int stall);
      send(x, y);
      wait_done();
      if (kidx >= 0) chk($sformatf("direct_%0dx%0d_k%0d", x, y, kidx), pw[kidx], expc);
      repeat (stall) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("post_hs_valid", ov[0], 0);
      chk("post_hs_ready", ir[0], 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] held;
      int x, y;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < NK; k++) begin
         chk($sformatf("rst_ready_k%0d", k), ir[k], 1);
         chk($sformatf("rst_valid_k%0d", k), ov[k], 0);
         chk($sformatf("rst_prod_k%0d", k), pw[k], 0);
      end

      run_one(255, 255, 0, 65025, 0);
      run_one(3, 3, 4, 7, 0);
      run_one(3, 3, 0, 9, 1);
      run_one(15, 1, 4, 15, 0);
      run_one(0, 200, 4, 0, 2);

      // Back-pressure with a competing request that must be ignored.
      send(201, 173);
      wait_done();
      held = pw[0];
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         a = W'($urandom);
         b = W'($urandom);
         @(posedge clk); #1;
         chk("bp_valid", ov[0], 1);
         chk("bp_stable", pw[0], held);
         chk("bp_ready", ir[0], 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release_ready", ir[0], 1);
      chk("bp_release_valid", ov[0], 0);

      // Reset while the step counter is 3; the operation is abandoned.
      send(77, 99);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      void'(exp_q.pop_back());
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_ready", ir[0], 1);
      chk("midrst_valid", ov[0], 0);
      chk("midrst_prod", pw[0], 0);
      chk("midrst_prod_k6", pw[6], 0);
      run_one(2, 5, 0, 10, 0);

      for (int i = 0; i < 40; i++) begin
         x = int'($urandom_range(0, 255));
         y = (i % 8 == 0) ? 0 : int'($urandom_range(0, 255));
         run_one(x, y, -1, 0, int'($urandom_range(0, 3)));
      end

      chk("sb_drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
